// File: rtl/calendar_pkg.sv
// Shared types and constants for the calendar clock controller.
// Field widths, month encodings, month lengths and the FSM state type.
package calendar_pkg;

  localparam int unsigned SecW   = 6;
  localparam int unsigned MinW   = 6;
  localparam int unsigned HourW  = 5;
  localparam int unsigned DayW   = 5;
  localparam int unsigned MonthW = 4;
  localparam int unsigned YearW  = 16;

  localparam logic [DayW-1:0] Len28 = 5'd28;
  localparam logic [DayW-1:0] Len29 = 5'd29;
  localparam logic [DayW-1:0] Len30 = 5'd30;
  localparam logic [DayW-1:0] Len31 = 5'd31;

  localparam logic [MonthW-1:0] Jan = 4'd1;
  localparam logic [MonthW-1:0] Feb = 4'd2;
  localparam logic [MonthW-1:0] Mar = 4'd3;
  localparam logic [MonthW-1:0] Apr = 4'd4;
  localparam logic [MonthW-1:0] May = 4'd5;
  localparam logic [MonthW-1:0] Jun = 4'd6;
  localparam logic [MonthW-1:0] Jul = 4'd7;
  localparam logic [MonthW-1:0] Aug = 4'd8;
  localparam logic [MonthW-1:0] Sep = 4'd9;
  localparam logic [MonthW-1:0] Oct = 4'd10;
  localparam logic [MonthW-1:0] Nov = 4'd11;
  localparam logic [MonthW-1:0] Dec = 4'd12;

  typedef enum logic {
    StRun,
    StCheck
  } state_e;

endpackage

// File: rtl/month_len_calc.sv
// Gregorian month length for a given month/year; 0 for an out-of-range month.
// Purely combinational; the century terms use constant-divisor modulo only.
module month_len_calc
  import calendar_pkg::*;
(
  input  logic [MonthW-1:0] month,
  input  logic [YearW-1:0]  year,
  output logic [DayW-1:0]   len
);

  logic leap;

  assign leap = ((year[1:0] == 2'b00) && ((year % 16'd100) != 16'd0)) ||
                ((year % 16'd400) == 16'd0);

  always_comb begin
    case (month)
      Jan, Mar, May, Jul, Aug, Oct, Dec: len = Len31;
      Apr, Jun, Sep, Nov:                len = Len30;
      Feb:                               len = leap ? Len29 : Len28;
      default:                           len = '0;
    endcase
  end

endmodule

// File: rtl/calendar_clock_ctrl.sv
// Time-of-day and calendar sequencer: 1 Hz cascade plus validated atomic set.
// A rejected set that collides with a tick defers that tick to the next RUN cycle.
module calendar_clock_ctrl
  import calendar_pkg::*;
#(
  parameter int unsigned YEAR_MIN = 2000,
  parameter int unsigned YEAR_MAX = 2199,
  parameter int unsigned RST_YEAR = 2000
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              tick_1hz,
  input  logic              set_req,
  input  logic [SecW-1:0]   set_sec,
  input  logic [MinW-1:0]   set_min,
  input  logic [HourW-1:0]  set_hour,
  input  logic [DayW-1:0]   set_day,
  input  logic [MonthW-1:0] set_month,
  input  logic [YearW-1:0]  set_year,
  output logic              set_ack,
  output logic              set_err,
  output logic [SecW-1:0]   sec,
  output logic [MinW-1:0]   min,
  output logic [HourW-1:0]  hour,
  output logic [DayW-1:0]   day,
  output logic [MonthW-1:0] month,
  output logic [YearW-1:0]  year,
  output logic              day_roll,
  output logic              year_roll
);

  localparam logic [YearW-1:0] YearMinL = YearW'(YEAR_MIN);
  localparam logic [YearW-1:0] YearMaxL = YearW'(YEAR_MAX);
  localparam logic [YearW-1:0] RstYearL = YearW'(RST_YEAR);

  state_e state_q, state_d;
  logic   set_req_q, pending_q, pending_d;
  logic   ack_q, ack_d, err_q, err_d, droll_q, droll_d, yroll_q, yroll_d;

  logic [SecW-1:0]   sec_q, sec_d, sh_sec_q, sh_sec_d, inc_sec;
  logic [MinW-1:0]   min_q, min_d, sh_min_q, sh_min_d, inc_min;
  logic [HourW-1:0]  hour_q, hour_d, sh_hour_q, sh_hour_d, inc_hour;
  logic [DayW-1:0]   day_q, day_d, sh_day_q, sh_day_d, inc_day;
  logic [MonthW-1:0] month_q, month_d, sh_month_q, sh_month_d, inc_month;
  logic [YearW-1:0]  year_q, year_d, sh_year_q, sh_year_d, inc_year;
  logic              inc_droll, inc_yroll;

  logic [DayW-1:0] ml_live, ml_shadow;
  logic            set_rise, advance, shadow_valid;

  month_len_calc u_len_live (
    .month (month_q),
    .year  (year_q),
    .len   (ml_live)
  );

  month_len_calc u_len_shadow (
    .month (sh_month_q),
    .year  (sh_year_q),
    .len   (ml_shadow)
  );

  assign set_rise = set_req & ~set_req_q;
  assign advance  = (state_q == StRun) & (tick_1hz | pending_q);

  assign shadow_valid = (sh_sec_q < 6'd60) && (sh_min_q < 6'd60) && (sh_hour_q < 5'd24) &&
                        (sh_month_q >= Jan) && (sh_month_q <= Dec) &&
                        (sh_year_q >= YearMinL) && (sh_year_q <= YearMaxL) &&
                        (sh_day_q != '0) && (sh_day_q <= ml_shadow);

  // One-second cascade from the live registers.
  always_comb begin
    inc_sec   = sec_q;
    inc_min   = min_q;
    inc_hour  = hour_q;
    inc_day   = day_q;
    inc_month = month_q;
    inc_year  = year_q;
    inc_droll = 1'b0;
    inc_yroll = 1'b0;
    if (sec_q >= 6'd59) begin
      inc_sec = '0;
      if (min_q >= 6'd59) begin
        inc_min = '0;
        if (hour_q >= 5'd23) begin
          inc_hour  = '0;
          inc_droll = 1'b1;
          if (day_q >= ml_live) begin
            inc_day = 5'd1;
            if (month_q >= Dec) begin
              inc_month = Jan;
              inc_yroll = 1'b1;
              inc_year  = (year_q >= YearMaxL) ? YearMinL : year_q + 16'd1;
            end else begin
              inc_month = month_q + 4'd1;
            end
          end else begin
            inc_day = day_q + 5'd1;
          end
        end else begin
          inc_hour = hour_q + 5'd1;
        end
      end else begin
        inc_min = min_q + 6'd1;
      end
    end else begin
      inc_sec = sec_q + 6'd1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StRun;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StRun:   if (set_rise) state_d = StCheck;
      StCheck: state_d = StRun;
      default: state_d = StRun;
    endcase
  end

  always_comb begin
    sec_d      = sec_q;
    min_d      = min_q;
    hour_d     = hour_q;
    day_d      = day_q;
    month_d    = month_q;
    year_d     = year_q;
    sh_sec_d   = sh_sec_q;
    sh_min_d   = sh_min_q;
    sh_hour_d  = sh_hour_q;
    sh_day_d   = sh_day_q;
    sh_month_d = sh_month_q;
    sh_year_d  = sh_year_q;
    pending_d  = pending_q;
    ack_d      = 1'b0;
    err_d      = 1'b0;
    droll_d    = 1'b0;
    yroll_d    = 1'b0;
    unique case (state_q)
      StRun: begin
        pending_d = 1'b0;
        if (advance) begin
          sec_d   = inc_sec;
          min_d   = inc_min;
          hour_d  = inc_hour;
          day_d   = inc_day;
          month_d = inc_month;
          year_d  = inc_year;
          droll_d = inc_droll;
          yroll_d = inc_yroll;
        end
        if (set_rise) begin
          sh_sec_d   = set_sec;
          sh_min_d   = set_min;
          sh_hour_d  = set_hour;
          sh_day_d   = set_day;
          sh_month_d = set_month;
          sh_year_d  = set_year;
        end
      end
      StCheck: begin
        if (shadow_valid) begin
          sec_d     = sh_sec_q;
          min_d     = sh_min_q;
          hour_d    = sh_hour_q;
          day_d     = sh_day_q;
          month_d   = sh_month_q;
          year_d    = sh_year_q;
          ack_d     = 1'b1;
          pending_d = 1'b0;
        end else begin
          // Accepted sets override a colliding tick; rejected ones keep it.
          err_d     = 1'b1;
          pending_d = tick_1hz;
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      set_req_q  <= 1'b0;
      pending_q  <= 1'b0;
      ack_q      <= 1'b0;
      err_q      <= 1'b0;
      droll_q    <= 1'b0;
      yroll_q    <= 1'b0;
      sec_q      <= '0;
      min_q      <= '0;
      hour_q     <= '0;
      day_q      <= 5'd1;
      month_q    <= Jan;
      year_q     <= RstYearL;
      sh_sec_q   <= '0;
      sh_min_q   <= '0;
      sh_hour_q  <= '0;
      sh_day_q   <= '0;
      sh_month_q <= '0;
      sh_year_q  <= '0;
    end else begin
      set_req_q  <= set_req;
      pending_q  <= pending_d;
      ack_q      <= ack_d;
      err_q      <= err_d;
      droll_q    <= droll_d;
      yroll_q    <= yroll_d;
      sec_q      <= sec_d;
      min_q      <= min_d;
      hour_q     <= hour_d;
      day_q      <= day_d;
      month_q    <= month_d;
      year_q     <= year_d;
      sh_sec_q   <= sh_sec_d;
      sh_min_q   <= sh_min_d;
      sh_hour_q  <= sh_hour_d;
      sh_day_q   <= sh_day_d;
      sh_month_q <= sh_month_d;
      sh_year_q  <= sh_year_d;
    end
  end

  assign set_ack   = ack_q;
  assign set_err   = err_q;
  assign sec       = sec_q;
  assign min       = min_q;
  assign hour      = hour_q;
  assign day       = day_q;
  assign month     = month_q;
  assign year      = year_q;
  assign day_roll  = droll_q;
  assign year_roll = yroll_q;

endmodule

// File: tb/tb_calendar_clock_ctrl.sv
// Self-checking bench for calendar_clock_ctrl: directed scenarios plus random
// tick/set traffic against a transaction-level calendar model.
module tb_calendar_clock_ctrl;

  logic        clk, rst_n, tick_1hz, set_req;
  logic [5:0]  set_sec, set_min, sec, min;
  logic [4:0]  set_hour, set_day, hour, day;
  logic [3:0]  set_month, month;
  logic [15:0] set_year, year;
  logic        set_ack, set_err, day_roll, year_roll;

  int checks = 0;
  int errors = 0;

  int m_sec, m_min, m_hour, m_day, m_mon, m_year;

  calendar_clock_ctrl #(
    .YEAR_MIN (2000),
    .YEAR_MAX (2199),
    .RST_YEAR (2000)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .tick_1hz  (tick_1hz),
    .set_req   (set_req),
    .set_sec   (set_sec),
    .set_min   (set_min),
    .set_hour  (set_hour),
    .set_day   (set_day),
    .set_month (set_month),
    .set_year  (set_year),
    .set_ack   (set_ack),
    .set_err   (set_err),
    .sec       (sec),
    .min       (min),
    .hour      (hour),
    .day       (day),
    .month     (month),
    .year      (year),
    .day_roll  (day_roll),
    .year_roll (year_roll)
  );

  always #5 clk = ~clk;

  logic [41:0] now_vec;
  assign now_vec = {year, month, day, hour, min, sec};

  function automatic int ml(int mo, int y);
    bit lp;
    lp = ((y % 4 == 0) && (y % 100 != 0)) || (y % 400 == 0);
    if (mo == 2) return lp ? 29 : 28;
    if (mo == 4 || mo == 6 || mo == 9 || mo == 11) return 30;
    if (mo >= 1 && mo <= 12) return 31;
    return 0;
  endfunction

  function automatic bit is_valid(int y, int mo, int d, int h, int mi, int s);
    return s < 60 && mi < 60 && h < 24 && mo >= 1 && mo <= 12 && y >= 2000 && y <= 2199 &&
           d >= 1 && d <= ml(mo, y);
  endfunction

  function automatic logic [41:0] mvec();
    return {16'(m_year), 4'(m_mon), 5'(m_day), 5'(m_hour), 6'(m_min), 6'(m_sec)};
  endfunction

  task automatic model_reset();
    m_sec = 0; m_min = 0; m_hour = 0; m_day = 1; m_mon = 1; m_year = 2000;
  endtask

  task automatic model_tick(output bit dr, output bit yr);
    dr = 0;
    yr = 0;
    m_sec++;
    if (m_sec == 60) begin
      m_sec = 0; m_min++;
      if (m_min == 60) begin
        m_min = 0; m_hour++;
        if (m_hour == 24) begin
          m_hour = 0; m_day++; dr = 1;
          if (m_day > ml(m_mon, m_year)) begin
            m_day = 1; m_mon++;
            if (m_mon == 13) begin
              m_mon = 1; yr = 1;
              m_year = (m_year == 2199) ? 2000 : m_year + 1;
            end
          end
        end
      end
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic do_tick(input string name);
    bit dr, yr;
    tick_1hz = 1'b1;
    cyc();
    tick_1hz = 1'b0;
    model_tick(dr, yr);
    checks++;
    if ({now_vec, day_roll, year_roll} !== {mvec(), dr, yr}) begin
      errors++;
      $display("FAIL %s: got time=%h rolls=%b%b exp time=%h rolls=%b%b", name, now_vec,
               day_roll, year_roll, mvec(), dr, yr);
    end
  endtask

  task automatic do_set(input string name, input int y, input int mo, input int d,
                        input int h, input int mi, input int s, input bit tick_chk);
    bit ok, dr, yr;
    ok        = is_valid(y, mo, d, h, mi, s);
    set_year  = 16'(y);
    set_month = 4'(mo);
    set_day   = 5'(d);
    set_hour  = 5'(h);
    set_min   = 6'(mi);
    set_sec   = 6'(s);
    set_req   = 1'b1;
    cyc();
    set_req  = 1'b0;
    tick_1hz = tick_chk;
    checks++;
    if ({set_ack, set_err} !== 2'b00) begin
      errors++;
      $display("FAIL %s early_resp: got ack/err=%b%b exp 00", name, set_ack, set_err);
    end
    cyc();
    tick_1hz = 1'b0;
    checks++;
    if ({set_ack, set_err} !== {ok, !ok}) begin
      errors++;
      $display("FAIL %s resp: got ack/err=%b%b exp %b%b", name, set_ack, set_err, ok, !ok);
    end
    if (ok) begin
      m_year = y; m_mon = mo; m_day = d; m_hour = h; m_min = mi; m_sec = s;
    end
    checks++;
    if (now_vec !== mvec()) begin
      errors++;
      $display("FAIL %s time: got %h exp %h", name, now_vec, mvec());
    end
    if (!ok && tick_chk) begin
      model_tick(dr, yr);
      cyc();
      checks++;
      if ({now_vec, day_roll, year_roll, set_ack, set_err} !== {mvec(), dr, yr, 2'b00}) begin
        errors++;
        $display("FAIL %s deferred_tick: got %h %b%b%b%b exp %h %b%b00", name, now_vec,
                 day_roll, year_roll, set_ack, set_err, mvec(), dr, yr);
      end
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    model_reset();
    checks++;
    if ({now_vec, set_ack, set_err, day_roll, year_roll} !== {mvec(), 4'b0000}) begin
      errors++;
      $display("FAIL reset_state: got %h %b%b%b%b exp %h 0000", now_vec, set_ack, set_err,
               day_roll, year_roll, mvec());
    end
    rst_n = 1'b1;
    cyc();
    repeat (3) do_tick("reset_tick");
    checks++;
    if (now_vec !== {16'd2000, 4'd1, 5'd1, 5'd0, 6'd0, 6'd3}) begin
      errors++;
      $display("FAIL three_ticks: got %h exp 00:00:03 2000-01-01", now_vec);
    end
  endtask

  task automatic test_set_rollover();
    do_set("set_feb28", 2023, 2, 28, 23, 59, 59, 1'b0);
    do_tick("roll_mar1");
  endtask

  task automatic test_leap();
    do_set("leap2024", 2024, 2, 28, 23, 59, 59, 1'b0);
    do_tick("to_feb29");
    do_set("nonleap2100", 2100, 2, 28, 23, 59, 59, 1'b0);
    do_tick("to_mar1_2100");
    do_set("feb29_2000", 2000, 2, 29, 1, 2, 3, 1'b0);
    do_set("feb29_2023", 2023, 2, 29, 1, 2, 3, 1'b0);
  endtask

  task automatic test_month_len();
    do_set("nov31", 2023, 11, 31, 5, 5, 5, 1'b0);
    do_set("dec31", 2023, 12, 31, 23, 59, 59, 1'b0);
    do_tick("new_year");
  endtask

  task automatic test_year_wrap();
    do_set("y2199", 2199, 12, 31, 23, 59, 59, 1'b0);
    do_tick("wrap_2000");
    do_set("y2200", 2200, 1, 1, 0, 0, 0, 1'b0);
  endtask

  task automatic test_races();
    do_set("at_10h", 2030, 5, 5, 10, 0, 0, 1'b0);
    do_set("rej_tick", 2030, 13, 5, 10, 0, 0, 1'b1);
    do_set("acc_tick", 2077, 7, 7, 7, 7, 7, 1'b1);
    // Reset lands in the CHECK cycle of a valid set.
    set_year = 16'd2111; set_month = 4'd3; set_day = 5'd3;
    set_hour = 5'd3; set_min = 6'd3; set_sec = 6'd3;
    set_req = 1'b1;
    cyc();
    set_req = 1'b0;
    rst_n   = 1'b0;
    #1;
    model_reset();
    checks++;
    if (now_vec !== mvec()) begin
      errors++;
      $display("FAIL rst_in_check: got %h exp %h", now_vec, mvec());
    end
    repeat (2) cyc();
    rst_n = 1'b1;
    repeat (3) begin
      cyc();
      checks++;
      if ({now_vec, set_ack, set_err} !== {mvec(), 2'b00}) begin
        errors++;
        $display("FAIL rst_no_resp: got %h %b%b exp %h 00", now_vec, set_ack, set_err, mvec());
      end
    end
  endtask

  task automatic test_held();
    int acks = 0;
    int errs = 0;
    set_year = 16'd2050; set_month = 4'd6; set_day = 5'd15;
    set_hour = 5'd12; set_min = 6'd34; set_sec = 6'd56;
    set_req = 1'b1;
    repeat (12) begin
      cyc();
      if (set_ack) acks++;
      if (set_err) errs++;
    end
    set_req = 1'b0;
    cyc();
    m_year = 2050; m_mon = 6; m_day = 15; m_hour = 12; m_min = 34; m_sec = 56;
    checks++;
    if (acks != 1 || errs != 0 || now_vec !== mvec()) begin
      errors++;
      $display("FAIL held_req: got acks=%0d errs=%0d time=%h exp acks=1 errs=0 time=%h",
               acks, errs, now_vec, mvec());
    end
  endtask

  task automatic test_random();
    int y, mo, d;
    for (int i = 0; i < 300; i++) begin
      case ($urandom_range(0, 3))
        0, 1: do_tick("rnd_tick");
        2: begin
          y  = $urandom_range(2000, 2199);
          mo = $urandom_range(1, 12);
          do_set("rnd_eom", y, mo, ml(mo, y), 23, 59, 59 - $urandom_range(0, 2),
                 1'($urandom_range(0, 1)));
        end
        default: begin
          do_set("rnd_set", $urandom_range(1995, 2205), $urandom_range(0, 13),
                 $urandom_range(0, 31), $urandom_range(0, 25), $urandom_range(0, 61),
                 $urandom_range(0, 61), 1'($urandom_range(0, 1)));
        end
      endcase
    end
  endtask

  initial begin
    clk = 1'b0; rst_n = 1'b0; tick_1hz = 1'b0; set_req = 1'b0;
    set_sec = '0; set_min = '0; set_hour = '0; set_day = '0; set_month = '0; set_year = '0;
    model_reset();
    test_reset();
    test_set_rollover();
    test_leap();
    test_month_len();
    test_year_wrap();
    test_races();
    test_held();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
